// File: rtl/cof_read_seq.sv
// cof_read_seq: streams a burst of coefficient words from a single-port
// synchronous memory (1-cycle read latency) to a valid/ready consumer.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   start                 one-cycle burst request (accepted only in IDLE)
//   base_addr, length     burst first address and word count, sampled with start
//   busy, done            burst in progress / one-cycle completion pulse
//   cen, read_wen         memory chip enable (active-low), write enable (held 1)
//   read_addr             memory read address
//   mem_rdata             memory read data, valid the cycle after cen=0
//   cof_data, cof_valid,  coefficient stream to the consumer;
//   cof_ready, cof_last   cof_last marks the final word of the burst
//
// Reads are credit-limited so that words buffered plus reads in flight never
// exceed the 2-entry skid FIFO. cen is decoded combinationally from state so a
// word popped in the same cycle frees a slot immediately; this is what allows
// one word per cycle with a 1-cycle memory and a registered FIFO head.
module cof_read_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  cen,
    output logic                  read_wen,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] cof_data,
    output logic                  cof_valid,
    input  logic                  cof_ready,
    output logic                  cof_last
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued;      // reads issued so far = next issue index
    logic                  rd_pend;     // a read was issued last cycle; data on mem_rdata now
    logic                  rd_last_pend;

    // 2-entry FIFO, entry 0 is the head
    logic [1:0]            cnt;
    logic [DATA_WIDTH-1:0] d0, d1;
    logic                  l0, l1;

    logic                  push, pop, issue, issue_last;
    logic [1:0]            occ_nxt;

    assign push      = rd_pend;
    assign cof_valid = (cnt != 2'd0);
    assign pop       = cof_valid & cof_ready;
    // Occupancy after this edge; a pop this cycle is credited right away.
    assign occ_nxt   = cnt - {1'b0, pop} + {1'b0, push};

    assign issue      = (state == FETCH) && (issued != len_q) && (occ_nxt < 2'd2);
    assign issue_last = (issued == (len_q - LEN_WIDTH'(1)));

    assign cen       = ~issue;
    assign read_wen  = 1'b1;
    assign cof_data  = d0;
    assign cof_last  = l0 & cof_valid;

    // Read-return capture and FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend      <= 1'b0;
            rd_last_pend <= 1'b0;
            cnt          <= 2'd0;
            d0           <= '0;
            d1           <= '0;
            l0           <= 1'b0;
            l1           <= 1'b0;
        end else begin
            rd_pend      <= issue;
            rd_last_pend <= issue & issue_last;
            cnt          <= occ_nxt;
            // Head loads incoming data when it would otherwise be empty,
            // else shifts up from entry 1 on a pop.
            if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) begin
                d0 <= mem_rdata;
                l0 <= rd_last_pend;
            end else if (pop) begin
                d0 <= d1;
                l0 <= l1;
            end
            if (push && ((cnt == 2'd1 && !pop) || cnt == 2'd2)) begin
                d1 <= mem_rdata;
                l1 <= rd_last_pend;
            end
        end
    end

    // Burst control FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            len_q     <= '0;
            issued    <= '0;
            read_addr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            len_q     <= length;
                            read_addr <= base_addr;
                            issued    <= '0;
                            busy      <= 1'b1;
                            state     <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        issued <= issued + LEN_WIDTH'(1);
                        // read_addr holds the address currently presented;
                        // advance it for the next issue (wraps naturally).
                        read_addr <= read_addr + ADDR_WIDTH'(1);
                        if (issue_last)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && l0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cof_read_seq.sv
// Bench for cof_read_seq: a behavioural 1-cycle memory, a scoreboard of
// expected read addresses and output words filled when each burst is
// requested, and a negedge monitor that pops and compares.
module tb_cof_read_seq;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic          cof_ready = 1'b1;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy, done, cen, read_wen, cof_valid, cof_last;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] cof_data;

    cof_read_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .cen(cen), .read_wen(read_wen), .read_addr(read_addr),
        .mem_rdata(mem_rdata), .cof_data(cof_data), .cof_valid(cof_valid),
        .cof_ready(cof_ready), .cof_last(cof_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return {20'hC0F00, a};
    endfunction

    // Synchronous read memory: data appears the cycle after cen=0.
    always @(posedge clk) if (!cen) mem_rdata <= mem_val(read_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard and monitor state
    logic [AW-1:0] q_addr[$];
    logic [DW:0]   q_word[$];     // {last, data}
    bit            mon_en = 1'b0;
    bit            ready_toggle = 1'b0;
    int            words = 0, done_cnt = 0, issued_n = 0;
    int            first_valid_cyc = -1, done_cyc = -1, s_cyc = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        cof_ready = ready_toggle ? ~cof_ready : 1'b1;
    end

    initial forever begin
        logic [DW:0] w;
        @(negedge clk);
        if (mon_en) begin
            chk("read_wen", 64'(read_wen), 64'(1));
            if (!cen) begin
                chk("outstanding_le2", 64'((issued_n - words) <= 2), 64'(1));
                if (q_addr.size() == 0) chk("unexpected_read", 64'(read_addr), 64'('1));
                else chk("read_addr", 64'(read_addr), 64'(q_addr.pop_front()));
                issued_n++;
            end
            if (cof_valid && prev_stall) begin
                chk("stall_data", 64'(cof_data), 64'(prev_data));
                chk("stall_last", 64'(cof_last), 64'(prev_last));
            end
            if (cof_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (cof_valid && cof_ready) begin
                if (q_word.size() == 0) chk("unexpected_word", 64'(cof_data), 64'('1));
                else begin
                    w = q_word.pop_front();
                    chk("cof_data", 64'(cof_data), 64'(w[DW-1:0]));
                    chk("cof_last", 64'(cof_last), 64'(w[DW]));
                end
                words++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_in_done", 64'(busy), 64'(0));
            end
            prev_stall = cof_valid && !cof_ready;
            prev_data  = cof_data;
            prev_last  = cof_last;
        end
    end

    task automatic reset_vals(input string tag);
        chk({tag, "_busy"},      64'(busy),      64'(0));
        chk({tag, "_done"},      64'(done),      64'(0));
        chk({tag, "_cen"},       64'(cen),       64'(1));
        chk({tag, "_read_wen"},  64'(read_wen),  64'(1));
        chk({tag, "_read_addr"}, 64'(read_addr), 64'(0));
        chk({tag, "_cof_valid"}, 64'(cof_valid), 64'(0));
        chk({tag, "_cof_last"},  64'(cof_last),  64'(0));
        chk({tag, "_cof_data"},  64'(cof_data),  64'(0));
    endtask

    task automatic begin_burst(input logic [AW-1:0] b, input int len);
        logic [AW-1:0] a;
        for (int i = 0; i < len; i++) begin
            a = b + AW'(i);
            q_addr.push_back(a);
            q_word.push_back({(i == len - 1), mem_val(a)});
        end
        words = 0; done_cnt = 0; issued_n = 0;
        first_valid_cyc = -1; done_cyc = -1; prev_stall = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = b; length = LW'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
        s_cyc = cyc;
        chk("busy_after_start", 64'(busy), 64'(len != 0));
    endtask

    task automatic finish_burst(input int len, input int done_lat);
        for (int i = 0; i < 400 && done_cnt == 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", 64'(done_cnt), 64'(1));
        chk("words", 64'(words), 64'(len));
        chk("reads", 64'(issued_n), 64'(len));
        chk("words_left", 64'(q_word.size()), 64'(0));
        if (len > 0) chk("first_valid_lat", 64'(first_valid_cyc - s_cyc), 64'(2));
        if (done_lat >= 0) chk("done_lat", 64'(done_cyc - s_cyc), 64'(done_lat));
        chk("busy_idle", 64'(busy), 64'(0));
        q_addr.delete();
        q_word.delete();
    endtask

    typedef struct {
        logic [AW-1:0] base;
        int            len;
        bit            tog;
        int            done_lat;   // -1: not checked (consumer stalls)
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{12'h010, 4, 1'b0, 6};
        vecs[1] = '{12'hFFE, 4, 1'b0, 6};
        vecs[2] = '{12'h123, 8, 1'b1, -1};
        vecs[3] = '{12'h7FF, 1, 1'b0, 3};
        vecs[4] = '{12'hABC, 2, 1'b1, -1};

        #12;
        reset_vals("rst0");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) begin
            ready_toggle = vecs[k].tog;
            begin_burst(vecs[k].base, vecs[k].len);
            finish_burst(vecs[k].len, vecs[k].done_lat);
            ready_toggle = 1'b0;
        end

        // Zero length, plus a start landing in the DONE cycle that must be ignored
        begin_burst(12'h040, 0);
        start = 1'b1; base_addr = 12'h050; length = 12'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_burst(0, 0);

        // Start while busy is ignored
        ready_toggle = 1'b1;
        begin_burst(12'h300, 5);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; base_addr = 12'h555; length = 12'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_burst(5, -1);
        ready_toggle = 1'b0;

        // Reset mid-burst after two words delivered
        begin_burst(12'h200, 6);
        for (int i = 0; i < 50 && words < 2; i++) @(posedge clk);
        #2;
        chk("words_before_rst", 64'(words), 64'(2));
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        reset_vals("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        q_addr.delete();
        q_word.delete();
        done_cnt = 0; issued_n = 0; words = 0; prev_stall = 1'b0;
        mon_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no_done_after_rst", 64'(done_cnt), 64'(0));
        chk("no_read_after_rst", 64'(issued_n), 64'(0));
        chk("no_word_after_rst", 64'(words), 64'(0));
        begin_burst(12'hFFE, 3);
        finish_burst(3, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
